// File: rtl/rr_mux_arb_4_1.sv
// rr_mux_arb_4_1: round-robin arbiter and sequencer for a 4:1 data mux.
// Grants one of four valid/ready requesters and registers the selected word
// in a one-deep output stage. The grant stays with one requester until
// req_last ends its burst.
// Optional macro RR_MUX_ARB_STATS_EN adds the grant_cnt outputs and the
// stats_clr input. These are per-requester saturating burst counters.
module rr_mux_arb_4_1 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req_valid,
  input  logic [3:0]          req_last,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          req_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic [SEL_W-1:0]    out_sel,
  input  logic                out_ready,
  output logic                busy
`ifdef RR_MUX_ARB_STATS_EN
  ,
  output logic [4*CNT_W-1:0]  grant_cnt,
  input  logic                stats_clr
`endif
);

  // The select logic is written for exactly four requesters.
  if (SEL_W != 2 || CNT_W < 1) begin : g_param_check
    $error("rr_mux_arb_4_1: SEL_W must be 2 and CNT_W at least 1");
  end

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] lk_q, lk_d;

  logic       load;
  logic       win_found;
  logic [1:0] winner;
  logic       xfer;
  logic       last_sel;

  assign load     = !out_valid | out_ready;
  // Reset gating keeps req_ready low while rst_n is asserted.
  assign xfer     = rst_n & load & win_found;
  assign last_sel = req_last[winner];

  // Winner selection: the locked index, or the first valid requester from ptr_q.
  always_comb begin
    logic [1:0] idx;
    winner    = ptr_q;
    win_found = 1'b0;
    idx       = ptr_q;
    if (state_q == StLocked) begin
      winner    = lk_q;
      win_found = req_valid[lk_q];
    end else begin
      // Scan from the far end so that the nearest valid requester wins.
      for (int k = 3; k >= 0; k--) begin
        idx = ptr_q + 2'(k);
        if (req_valid[idx]) begin
          winner    = idx;
          win_found = 1'b1;
        end
      end
    end
  end

  // State, lock index and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      lk_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lk_q    <= lk_d;
    end
  end

  // Next state: a burst locks on a non-last beat. The pointer advances only at burst end.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lk_d    = lk_q;
    if (xfer) begin
      if (last_sel) begin
        state_d = StIdle;
        ptr_d   = winner + 2'd1;
      end else begin
        state_d = StLocked;
        lk_d    = winner;
      end
    end
  end

  // FSM outputs: one-hot ready to the winner, and busy while locked.
  always_comb begin
    req_ready = 4'b0000;
    if (xfer) begin
      req_ready = 4'b0001 << winner;
    end
    busy = (state_q == StLocked);
  end

  // One-deep output register. A load with no transfer empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= req_data[int'(winner)*DATA_W +: DATA_W];
        out_last <= last_sel;
        out_sel  <= SEL_W'(winner);
      end
    end
  end

`ifdef RR_MUX_ARB_STATS_EN
  logic [3:0][CNT_W-1:0] cnt_q;

  // Completed-burst counters. A clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stats_clr) begin
      cnt_q <= '0;
    end else if (xfer && last_sel && (cnt_q[winner] != {CNT_W{1'b1}})) begin
      cnt_q[winner] <= cnt_q[winner] + 1'b1;
    end
  end

  assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_arb_4_1.sv
// Directed bench for rr_mux_arb_4_1. It covers reset, round robin,
// backpressure, burst lock, locked stall, reset mid-burst, and the stats
// counters when RR_MUX_ARB_STATS_EN is defined.
module tb_rr_mux_arb_4_1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [127:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready;
  logic        busy;
`ifdef RR_MUX_ARB_STATS_EN
  logic [63:0] grant_cnt;
  logic [7:0]  grant_cnt_sat;
  logic [3:0]  req_ready_sat;
  logic        out_valid_sat;
  logic [31:0] out_data_sat;
  logic        out_last_sat;
  logic [1:0]  out_sel_sat;
  logic        busy_sat;
  logic        stats_clr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_mux_arb_4_1 #(.DATA_W(32), .SEL_W(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef RR_MUX_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stats_clr (stats_clr)
`endif
  );

`ifdef RR_MUX_ARB_STATS_EN
  rr_mux_arb_4_1 #(.DATA_W(32), .SEL_W(2), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready_sat),
    .out_valid (out_valid_sat),
    .out_data  (out_data_sat),
    .out_last  (out_last_sat),
    .out_sel   (out_sel_sat),
    .out_ready (out_ready),
    .busy      (busy_sat),
    .grant_cnt (grant_cnt_sat),
    .stats_clr (stats_clr)
  );
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic l, input logic b);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".out_sel"}, 64'(out_sel), 64'(s));
    chk({tag, ".out_data"}, 64'(out_data), 64'(d));
    chk({tag, ".out_last"}, 64'(out_last), 64'(l));
    chk({tag, ".busy"}, 64'(busy), 64'(b));
  endtask

  task automatic lanes_default();
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hA0 + 32'(i);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    lanes_default();
    out_ready = 1'b1;
`ifdef RR_MUX_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    #2;
    chk_out("reset", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    chk("reset.req_ready", 64'(req_ready), 64'(4'b0000));
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_reset.req_ready", 64'(req_ready), 64'(4'b0001));

    // Round robin over four single-beat requesters.
    tick(); chk_out("rr0", 1'b1, 2'd0, 32'hA0, 1'b1, 1'b0);
    chk("rr0.req_ready", 64'(req_ready), 64'(4'b0010));
    tick(); chk_out("rr1", 1'b1, 2'd1, 32'hA1, 1'b1, 1'b0);
    chk("rr1.req_ready", 64'(req_ready), 64'(4'b0100));
    tick(); chk_out("rr2", 1'b1, 2'd2, 32'hA2, 1'b1, 1'b0);
    chk("rr2.req_ready", 64'(req_ready), 64'(4'b1000));
    tick(); chk_out("rr3", 1'b1, 2'd3, 32'hA3, 1'b1, 1'b0);
    tick(); chk_out("rr4", 1'b1, 2'd0, 32'hA0, 1'b1, 1'b0);

    // Backpressure: hold output stable and withhold ready for 4 cycles.
    out_ready = 1'b0;
    #1 chk("bp.req_ready", 64'(req_ready), 64'(4'b0000));
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out("bp_hold", 1'b1, 2'd0, 32'hA0, 1'b1, 1'b0);
      chk("bp_hold.req_ready", 64'(req_ready), 64'(4'b0000));
    end
    out_ready = 1'b1;
    #1 chk("bp_release.req_ready", 64'(req_ready), 64'(4'b0010));
    tick(); chk_out("bp_next", 1'b1, 2'd1, 32'hA1, 1'b1, 1'b0);

    // Burst lock on requester 2 (ptr is now 2) with requesters 0 and 1 waiting.
    req_valid = 4'b0111;
    req_last  = 4'b0011;
    req_data[64 +: 32] = 32'hB0;
    #1 chk("burst.req_ready", 64'(req_ready), 64'(4'b0100));
    tick(); chk_out("burst_b0", 1'b1, 2'd2, 32'hB0, 1'b0, 1'b1);
    req_data[64 +: 32] = 32'hB1;
    #1 chk("burst_b1.req_ready", 64'(req_ready), 64'(4'b0100));
    tick(); chk_out("burst_b1", 1'b1, 2'd2, 32'hB1, 1'b0, 1'b1);
    req_data[64 +: 32] = 32'hB2;
    req_last = 4'b0111;
    tick(); chk_out("burst_b2", 1'b1, 2'd2, 32'hB2, 1'b1, 1'b0);
    // Requester 3 idle, so the pointer at 3 wraps to requester 0.
    req_valid = 4'b0011;
    req_last  = 4'b1111;
    lanes_default();
    #1 chk("wrap.req_ready", 64'(req_ready), 64'(4'b0001));
    tick(); chk_out("wrap", 1'b1, 2'd0, 32'hA0, 1'b1, 1'b0);

    // Locked stall: lock on requester 1, then drop its valid while 3 requests.
    req_valid = 4'b1010;
    req_last  = 4'b1101;
    req_data[32 +: 32] = 32'hC0;
    tick(); chk_out("stall_b0", 1'b1, 2'd1, 32'hC0, 1'b0, 1'b1);
    req_valid = 4'b1000;
    #1 chk("stall.req_ready", 64'(req_ready), 64'(4'b0000));
    tick(); chk("stall1.out_valid", 64'(out_valid), 64'(1'b0));
    chk("stall1.busy", 64'(busy), 64'(1'b1));
    chk("stall1.req_ready", 64'(req_ready), 64'(4'b0000));
    tick(); chk("stall2.out_valid", 64'(out_valid), 64'(1'b0));
    chk("stall2.out_sel", 64'(out_sel), 64'(2'd1));
    req_valid = 4'b1010;
    req_last  = 4'b1111;
    req_data[32 +: 32] = 32'hC1;
    #1 chk("resume.req_ready", 64'(req_ready), 64'(4'b0010));
    tick(); chk_out("resume", 1'b1, 2'd1, 32'hC1, 1'b1, 1'b0);
    req_valid = 4'b1000;
    #1 chk("after_stall.req_ready", 64'(req_ready), 64'(4'b1000));

    // Reset in the middle of a burst from requester 3.
    req_last = 4'b0111;
    req_data[96 +: 32] = 32'hD0;
    tick(); chk_out("rst_burst", 1'b1, 2'd3, 32'hD0, 1'b0, 1'b1);
    req_valid = 4'b1111;
    rst_n     = 1'b0;
    #1 chk_out("rst_mid", 1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
    chk("rst_mid.req_ready", 64'(req_ready), 64'(4'b0000));
    #1 rst_n = 1'b1;
    req_last = 4'b1111;
    lanes_default();
    #1 chk("rst_rel.req_ready", 64'(req_ready), 64'(4'b0001));
    tick(); chk_out("rst_first", 1'b1, 2'd0, 32'hA0, 1'b1, 1'b0);

    // No requests: the output drains and out_sel holds.
    req_valid = 4'b0000;
    tick(); chk("idle.out_valid", 64'(out_valid), 64'(1'b0));
    chk("idle.out_sel", 64'(out_sel), 64'(2'd0));

`ifdef RR_MUX_ARB_STATS_EN
    stats_clr = 1'b1;
    tick(); chk("stats_clr0", grant_cnt, 64'h0);
    stats_clr = 1'b0;
    req_valid = 4'b0010;
    req_last  = 4'b1111;
    for (int c = 0; c < 5; c++) tick();
    req_valid = 4'b0000;
    chk("stats_five", grant_cnt, {16'd0, 16'd0, 16'd5, 16'd0});
    chk("stats_sat", 64'(grant_cnt_sat), 64'({2'd0, 2'd0, 2'd3, 2'd0}));
    // A clear in the same cycle as a completed burst must win.
    req_valid = 4'b0010;
    stats_clr = 1'b1;
    tick(); chk("stats_clr1", grant_cnt, 64'h0);
    chk("stats_clr1_sat", 64'(grant_cnt_sat), 64'h0);
    stats_clr = 1'b0;
    req_valid = 4'b0000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb_4_1.md
Name: rr_mux_arb_4_1

Overview:
- Round-robin arbiter and sequencer for a 4:1 data mux.
- Shares one 4-input data path between four requesters that use valid/ready handshakes.
- Produces the mux select, feeds the selected word into a one-deep output register, and holds the grant for a multi-beat burst until `req_last`.
- Sits between the four producer lanes and the single downstream consumer of the mux output.

Parameters:
- DATA_W, 32, data word width per requester and at the output.
- SEL_W, 2, select width; fixed at 2 for 4 requesters.
- CNT_W, 16, width of the per-requester grant counters (only used with the optional feature).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  4  per-requester valid; bit i belongs to requester i.
- req_last  input  4  per-requester last-beat-of-burst flag; qualified by req_valid[i].
- req_data  input  4*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  4  per-requester ready; one-hot or zero.
- out_valid  output  1  output register holds a valid word.
- out_data  output  DATA_W  registered selected word.
- out_last  output  1  registered last flag.
- out_sel  output  SEL_W  index of the requester whose word is in the output register.
- out_ready  input  1  downstream accept.
- busy  output  1  high while in LOCKED state.

Behaviour:
- Reset (async, rst_n=0) values:
  - out_valid=0, out_data=0, out_last=0, out_sel=0, busy=0.
  - Round-robin pointer ptr=0, state=IDLE.
  - req_ready=0 while rst_n=0.
- Load enable:
  - load = !out_valid | out_ready.
  - A transfer from requester i occurs when load & req_valid[i] & req_ready[i].
- Winner selection (combinational):
  - IDLE: first i with req_valid[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - LOCKED: winner is always the locked index lk, regardless of other requests.
- req_ready:
  - req_ready[winner] = load & req_valid[winner]; all other bits are 0.
  - In LOCKED with req_valid[lk]=0, req_ready=0 and the output loads nothing. The grant is not released.
- Output register on a transfer: out_data<=selected word, out_last<=req_last[winner], out_sel<=winner, out_valid<=1.
  - If load=1 and there is no transfer, out_valid<=0.
- Latency: 1 cycle from accepted request to out_valid. Full throughput is 1 word/cycle when out_ready stays high.
- State machine:
  - IDLE -> LOCKED: transfer with req_last=0. Set lk<=winner, busy=1.
  - IDLE stays IDLE: transfer with req_last=1 (single-beat burst).
  - LOCKED -> IDLE: transfer from lk with req_last=1.
  - Otherwise LOCKED holds.
- Pointer update:
  - ptr<=winner+1 (mod 4, natural wrap of 2 bits) only on a transfer with req_last=1, i.e. at burst end.
  - ptr is unchanged mid-burst.
- Backpressure: out_valid=1 & out_ready=0 keeps out_* stable and forces req_ready=0.
- Simultaneous requests: only the winner is served; the others keep valid asserted and are served in rotation. No requester waits more than 3 bursts.
- Reset mid-burst: returns to IDLE with ptr=0 and the output register cleared. The partial burst is dropped.
- No requests: out_sel keeps its last value and out_valid falls after the pending word is accepted.

Optional Feature:
- Macro: RR_MUX_ARB_STATS_EN.
- Defined:
  - Adds four CNT_W-bit saturating counters grant_cnt[i], each incremented on every completed burst (transfer with req_last=1) from requester i.
  - Exposed on output port grant_cnt, 4*CNT_W bits, packed like req_data.
  - Adds input stats_clr (1 bit), which synchronously zeroes all counters. stats_clr takes priority over a same-cycle increment.
  - Counters reset to 0 on rst_n=0.
  - Counters saturate at all-ones.
- Undefined: grant_cnt and stats_clr ports and all counter logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with req_valid=4'b1111 -> out_valid=0, req_ready=0 immediately. After release, the first grant goes to requester 0 (out_sel=0).
- Round robin: all 4 valid with req_last=1 continuously and out_ready=1 -> out_sel sequence 0,1,2,3,0. out_data matches each lane, for example lane i data = 32'hA0+i.
- Burst lock: req 2 sends 3 beats (last on beat 3) while req 0 and req 1 are valid -> out_sel=2 for 3 consecutive words and busy=1 during the first two beats. Next grant goes to 3 if valid, else wraps to 0.
- Backpressure: out_ready=0 for 4 cycles with out_valid=1 -> out_data/out_sel stable and req_ready=4'b0000. When out_ready=1 returns, the next word loads in the same cycle.
- Locked stall: in LOCKED on lk=1, req_valid[1] drops for 2 cycles while req 3 is valid -> no grant to 3, out_valid goes to 0, and the burst resumes on requester 1.
- Stats (RR_MUX_ARB_STATS_EN): 5 single-beat bursts from req 1, then pulse stats_clr -> grant_cnt[1]=5 before the pulse and 0 after. With CNT_W=2, the counter saturates at 3.
